// File: rtl/session_pkg.sv
// Shared types and constants for the session controller: state encoding,
// display/LED message codes and default parameter values.
package session_pkg;

  localparam int unsigned DEF_NUM_APPS     = 2;
  localparam int unsigned DEF_ID_W         = 16;
  localparam int unsigned DEF_MAX_TRIES    = 3;
  localparam int unsigned DEF_LOCK_CYCLES  = 1024;
  localparam int unsigned DEF_IDLE_TIMEOUT = 4096;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_AUTH    = 3'd1,
    ST_MENU    = 3'd2,
    ST_APP     = 3'd3,
    ST_LOCKOUT = 3'd4
  } state_e;

  localparam logic [2:0] LCD_IDLE       = 3'd0;
  localparam logic [2:0] LCD_AUTH       = 3'd1;
  localparam logic [2:0] LCD_AUTH_RETRY = 3'd2;
  localparam logic [2:0] LCD_MENU       = 3'd3;
  localparam logic [2:0] LCD_APP        = 3'd4;
  localparam logic [2:0] LCD_LOCKOUT    = 3'd5;
  localparam logic [2:0] LCD_TIMEOUT    = 3'd6;

  localparam logic [3:0] LED_IDLE    = 4'd0;
  localparam logic [3:0] LED_AUTH    = 4'd1;
  localparam logic [3:0] LED_SESSION = 4'd2;
  localparam logic [3:0] LED_LOCKOUT = 4'd8;

endpackage

// File: rtl/session_controller_if.sv
// User-facing bus of the session controller; slave = controller side,
// master = the host/board logic driving buttons and authenticator.
interface session_controller_if
  import session_pkg::*;
#(
  parameter int unsigned NUM_APPS = DEF_NUM_APPS,
  parameter int unsigned ID_W     = DEF_ID_W
);

  logic                btn_start;
  logic                btn_logout;
  logic                activity;
  logic [ID_W-1:0]     user_id_in;
  logic                auth_valid;
  logic                auth_ok;
  logic [NUM_APPS-1:0] app_req;
  logic [NUM_APPS-1:0] app_done;

  logic                auth_en;
  logic [NUM_APPS-1:0] app_sel;
  logic [ID_W-1:0]     userid;
  logic                locked;
  logic                timeout_pulse;
  logic [2:0]          lcd_code;
  logic [3:0]          led_code;
  logic [2:0]          state_o;

  modport master (
    output btn_start, btn_logout, activity, user_id_in, auth_valid, auth_ok,
           app_req, app_done,
    input  auth_en, app_sel, userid, locked, timeout_pulse, lcd_code,
           led_code, state_o
  );

  modport slave (
    input  btn_start, btn_logout, activity, user_id_in, auth_valid, auth_ok,
           app_req, app_done,
    output auth_en, app_sel, userid, locked, timeout_pulse, lcd_code,
           led_code, state_o
  );

endinterface

// File: rtl/session_timer.sv
// Loadable down-counter; load_i reloads MAX_VAL, dec_i counts toward zero.
// zero_o flags a decrement that lands on (or sits at) zero this cycle.
module session_timer #(
  parameter int unsigned MAX_VAL = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic load_i,
  input  logic dec_i,
  output logic zero_o
);

  localparam int unsigned CNT_W = $clog2(MAX_VAL + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk) begin
    if (!rst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end

  always_comb begin
    cnt_d = cnt_q;
    if (load_i)                           cnt_d = CNT_W'(MAX_VAL);
    else if (dec_i && (cnt_q != '0))      cnt_d = cnt_q - CNT_W'(1);
  end

  assign zero_o = !load_i && dec_i && (cnt_q <= CNT_W'(1));

endmodule

// File: rtl/session_controller.sv
// Login/session FSM: authentication with retry lockout, application
// selection, inactivity logout. All outputs are registered Moore outputs.
module session_controller
  import session_pkg::*;
#(
  parameter int unsigned NUM_APPS     = DEF_NUM_APPS,
  parameter int unsigned ID_W         = DEF_ID_W,
  parameter int unsigned MAX_TRIES    = DEF_MAX_TRIES,
  parameter int unsigned LOCK_CYCLES  = DEF_LOCK_CYCLES,
  parameter int unsigned IDLE_TIMEOUT = DEF_IDLE_TIMEOUT
) (
  input logic                 clk,
  input logic                 rst,
  session_controller_if.slave bus
);

  localparam int unsigned TRY_W = $clog2(MAX_TRIES + 1);

  state_e              state_q, state_d;
  logic [TRY_W-1:0]    try_q, try_d;
  logic [ID_W-1:0]     userid_q, userid_d;
  logic [NUM_APPS-1:0] app_sel_q, app_sel_d;
  logic                auth_en_q, auth_en_d;
  logic                locked_q, locked_d;
  logic                tmo_q, tmo_d;
  logic [2:0]          lcd_q, lcd_d;
  logic [3:0]          led_q, led_d;

  logic                in_session;
  logic                idle_load, idle_zero, lock_zero;
  logic [NUM_APPS-1:0] app_pick;

  // Idle timer is held at full scale outside AUTH/MENU so every entry starts
  // fresh; AUTH->MENU is the one in-session transition that needs a reload.
  assign in_session = (state_q == ST_AUTH) || (state_q == ST_MENU);
  assign idle_load  = !in_session || bus.activity ||
                      ((state_q == ST_AUTH) && bus.auth_valid && bus.auth_ok);

  session_timer #(.MAX_VAL(IDLE_TIMEOUT)) u_idle_timer (
    .clk    (clk),
    .rst    (rst),
    .load_i (idle_load),
    .dec_i  (!idle_load),
    .zero_o (idle_zero)
  );

  session_timer #(.MAX_VAL(LOCK_CYCLES)) u_lock_timer (
    .clk    (clk),
    .rst    (rst),
    .load_i (state_q != ST_LOCKOUT),
    .dec_i  (state_q == ST_LOCKOUT),
    .zero_o (lock_zero)
  );

  assign app_pick = bus.app_req & (~bus.app_req + NUM_APPS'(1));

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      try_q     <= '0;
      userid_q  <= '0;
      app_sel_q <= '0;
      auth_en_q <= 1'b0;
      locked_q  <= 1'b0;
      tmo_q     <= 1'b0;
      lcd_q     <= LCD_IDLE;
      led_q     <= LED_IDLE;
    end else begin
      state_q   <= state_d;
      try_q     <= try_d;
      userid_q  <= userid_d;
      app_sel_q <= app_sel_d;
      auth_en_q <= auth_en_d;
      locked_q  <= locked_d;
      tmo_q     <= tmo_d;
      lcd_q     <= lcd_d;
      led_q     <= led_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    try_d     = try_q;
    userid_d  = userid_q;
    app_sel_d = app_sel_q;
    tmo_d     = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (bus.btn_start) state_d = ST_AUTH;
      end
      ST_AUTH: begin
        if (bus.btn_logout) begin
          state_d  = ST_IDLE;
          userid_d = '0;
          try_d    = '0;
        end else if (bus.auth_valid) begin
          if (bus.auth_ok) begin
            state_d  = ST_MENU;
            userid_d = bus.user_id_in;
            try_d    = '0;
          end else begin
            try_d = try_q + TRY_W'(1);
            if (try_q >= TRY_W'(MAX_TRIES - 1)) begin
              try_d   = TRY_W'(MAX_TRIES);
              state_d = ST_LOCKOUT;
            end
          end
        end else if (idle_zero) begin
          state_d  = ST_IDLE;
          userid_d = '0;
          try_d    = '0;
          tmo_d    = 1'b1;
        end
      end
      ST_MENU: begin
        if (bus.btn_logout) begin
          state_d  = ST_IDLE;
          userid_d = '0;
          try_d    = '0;
        end else if (bus.app_req != '0) begin
          state_d   = ST_APP;
          app_sel_d = app_pick;
        end else if (idle_zero) begin
          state_d  = ST_IDLE;
          userid_d = '0;
          try_d    = '0;
          tmo_d    = 1'b1;
        end
      end
      ST_APP: begin
        if ((bus.app_done & app_sel_q) != '0) begin
          state_d   = ST_MENU;
          app_sel_d = '0;
        end
      end
      ST_LOCKOUT: begin
        if (lock_zero) begin
          state_d = ST_IDLE;
          try_d   = '0;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    auth_en_d = (state_d == ST_AUTH);
    locked_d  = (state_d == ST_LOCKOUT);
    lcd_d     = LCD_IDLE;
    led_d     = LED_IDLE;
    unique case (state_d)
      ST_IDLE:    lcd_d = tmo_d ? LCD_TIMEOUT : LCD_IDLE;
      ST_AUTH: begin
        lcd_d = (try_d != '0) ? LCD_AUTH_RETRY : LCD_AUTH;
        led_d = LED_AUTH;
      end
      ST_MENU: begin
        lcd_d = LCD_MENU;
        led_d = LED_SESSION;
      end
      ST_APP: begin
        lcd_d = LCD_APP;
        led_d = LED_SESSION;
      end
      ST_LOCKOUT: begin
        lcd_d = LCD_LOCKOUT;
        led_d = LED_LOCKOUT;
      end
      default: ;
    endcase
  end

  assign bus.auth_en       = auth_en_q;
  assign bus.app_sel       = app_sel_q;
  assign bus.userid        = userid_q;
  assign bus.locked        = locked_q;
  assign bus.timeout_pulse = tmo_q;
  assign bus.lcd_code      = lcd_q;
  assign bus.led_code      = led_q;
  assign bus.state_o       = state_q;

endmodule
